// File: rtl/serial_n_bit_adder_if.sv
// serial_n_bit_adder_if: start/done handshake with operand and result bundle
interface serial_n_bit_adder_if #(parameter int N = 4);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic [N-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;
    modport master (output start, a, b, carry_in, input sum, carry_out, overflow, busy, done);
    modport slave (input start, a, b, carry_in, output sum, carry_out, overflow, busy, done);
endinterface

// File: rtl/serial_n_bit_adder.sv
// serial_n_bit_adder: bit-serial LSB-first adder, one full-adder cell plus carry flop
module serial_n_bit_adder #(parameter int N = 4) (
    input logic            clk,
    input logic            rst_n,
    serial_n_bit_adder_if.slave bus
);
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  a_sh, b_sh, s_nx, sum_q;
    logic [CW-1:0] cnt;
    logic          c, s, c_nx, load, last, co_q, ov_q;
    always_comb begin
        s       = a_sh[0] ^ b_sh[0] ^ c;
        c_nx    = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
        load    = state_q != RUN && bus.start;
        last    = state_q == RUN && cnt == CW'(N - 1);
        state_d = state_q;
        if (load) state_d = RUN;
        else if (last) state_d = DONE;
        else if (state_q == DONE) state_d = IDLE;
    end
    // Only N-1 partial sum bits need storing; the last bit goes straight to sum.
    if (N == 1) begin : g_one
        assign s_nx = s;
    end else begin : g_wide
        logic [N-2:0] s_sh;
        always_ff @(posedge clk)
            if (!rst_n) s_sh <= '0;
            else if (state_q == RUN) s_sh <= s_nx[N-1:1];
        assign s_nx = {s, s_sh};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                a_sh <= bus.a;
                b_sh <= bus.b;
                c    <= bus.carry_in;
                cnt  <= '0;
            end else if (state_q == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                c    <= c_nx;
                cnt  <= cnt + CW'(1);
            end
            // c still holds the carry into the MSB on the final edge
            if (last) begin
                sum_q <= s_nx;
                co_q  <= c_nx;
                ov_q  <= c ^ c_nx;
            end
        end
    end
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
    assign bus.busy      = state_q == RUN;
    assign bus.done      = state_q == DONE;
endmodule
